// File: rtl/game_pkg.sv
// Shared types and constants for the StopIt round controller.
package game_pkg;

    localparam int unsigned COUNT_W = 5;
    localparam int unsigned SCORE_W = 3;
    localparam logic [COUNT_W-1:0] COUNT_MAX = 5'd31;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        LOAD    = 3'd2,
        RUN     = 3'd3,
        CORRECT = 3'd4,
        WRONG   = 3'd5,
        WON     = 3'd6
    } state_e;

endpackage

// File: rtl/game_fsm_rise_detect.sv
// One-bit rising-edge detector; the history register resets high so a
// level already asserted when reset releases does not register as an edge.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic level_i,
    output logic rise_c
);

    logic prev_q;

    // Remember last cycle's level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= level_i;
        end
    end

    assign rise_c = level_i & ~prev_q;

endmodule

// File: rtl/game_fsm.sv
// StopIt round controller: requests a target from the LFSR, runs the
// down-counter, judges the stop press and keeps score up to a win.
module game_fsm
    import game_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 25_000_000,
    parameter int unsigned SHOW_CYCLES = 50_000_000,
    parameter int unsigned WIN_COUNT   = 5
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic               stop_i,
    input  logic [COUNT_W-1:0] rand_i,
    output logic               next_o,
    output logic [COUNT_W-1:0] target_o,
    output logic [COUNT_W-1:0] count_o,
    output logic [SCORE_W-1:0] score_o,
    output logic               running_o,
    output logic               correct_o,
    output logic               wrong_o,
    output logic               won_o
);

    localparam int unsigned TICK_W = $clog2(TICK_CYCLES);
    localparam int unsigned SHOW_W = $clog2(SHOW_CYCLES + 1);

    localparam logic [TICK_W-1:0]  TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [SHOW_W-1:0]  SHOW_LAST = SHOW_W'(SHOW_CYCLES - 1);
    localparam logic [SCORE_W-1:0] WIN_SCORE = SCORE_W'(WIN_COUNT);

    state_e             state_q,   state_d;
    logic [COUNT_W-1:0] target_q,  target_d;
    logic [COUNT_W-1:0] count_q,   count_d;
    logic [SCORE_W-1:0] score_q,   score_d;
    logic [TICK_W-1:0]  tick_q,    tick_d;
    logic [SHOW_W-1:0]  show_q,    show_d;
    logic               next_q,    next_d;
    logic               running_q, running_d;
    logic               correct_q, correct_d;
    logic               wrong_q,   wrong_d;
    logic               won_q,     won_d;

    logic start_rise_c;
    logic stop_rise_c;

    rise_detect u_start_rise (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (start_i),
        .rise_c  (start_rise_c)
    );

    rise_detect u_stop_rise (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .level_i (stop_i),
        .rise_c  (stop_rise_c)
    );

    // State, datapath and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            target_q  <= '0;
            count_q   <= '0;
            score_q   <= '0;
            tick_q    <= '0;
            show_q    <= '0;
            next_q    <= 1'b0;
            running_q <= 1'b0;
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            won_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            target_q  <= target_d;
            count_q   <= count_d;
            score_q   <= score_d;
            tick_q    <= tick_d;
            show_q    <= show_d;
            next_q    <= next_d;
            running_q <= running_d;
            correct_q <= correct_d;
            wrong_q   <= wrong_d;
            won_q     <= won_d;
        end
    end

    // Next-state, datapath updates and Moore flags decoded from the next state.
    always_comb begin
        state_d  = state_q;
        target_d = target_q;
        count_d  = count_q;
        score_d  = score_q;
        tick_d   = tick_q;
        show_d   = show_q;

        case (state_q)
            IDLE: begin
                if (start_rise_c) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                target_d = rand_i;
                count_d  = COUNT_MAX;
                tick_d   = '0;
                state_d  = RUN;
            end
            RUN: begin
                // A stop press freezes the count shown this cycle, even on a tick.
                if (stop_rise_c) begin
                    show_d = '0;
                    if (count_q == target_q) begin
                        state_d = CORRECT;
                        if (score_q != WIN_SCORE) begin
                            score_d = score_q + SCORE_W'(1);
                        end
                    end else begin
                        state_d = WRONG;
                    end
                end else if (tick_q == TICK_LAST) begin
                    tick_d  = '0;
                    count_d = count_q - COUNT_W'(1);
                end else begin
                    tick_d = tick_q + TICK_W'(1);
                end
            end
            CORRECT: begin
                if (show_q == SHOW_LAST) begin
                    show_d  = '0;
                    state_d = (score_q == WIN_SCORE) ? WON : REQ;
                end else begin
                    show_d = show_q + SHOW_W'(1);
                end
            end
            WRONG: begin
                if (show_q == SHOW_LAST) begin
                    show_d  = '0;
                    score_d = '0;
                    state_d = IDLE;
                end else begin
                    show_d = show_q + SHOW_W'(1);
                end
            end
            WON: begin
                if (start_rise_c) begin
                    score_d = '0;
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        next_d    = (state_d == REQ);
        running_d = (state_d == RUN);
        correct_d = (state_d == CORRECT);
        wrong_d   = (state_d == WRONG);
        won_d     = (state_d == WON);
    end

    assign next_o    = next_q;
    assign target_o  = target_q;
    assign count_o   = count_q;
    assign score_o   = score_q;
    assign running_o = running_q;
    assign correct_o = correct_q;
    assign wrong_o   = wrong_q;
    assign won_o     = won_q;

endmodule

// File: tb/tb_game_fsm.sv
// Directed bench for game_fsm with a small LFSR model feeding rand_i.
module tb_game_fsm;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [4:0] rand_v;
    logic       next_v;
    logic [4:0] target_v;
    logic [4:0] count_v;
    logic [2:0] score_v;
    logic       running_v;
    logic       correct_v;
    logic       wrong_v;
    logic       won_v;

    int total = 0;
    int fails = 0;

    logic [4:0] lfsr = 5'h01;

    game_fsm #(
        .TICK_CYCLES (4),
        .SHOW_CYCLES (3),
        .WIN_COUNT   (2)
    ) dut (
        .clk_i     (clk),
        .rst_ni    (rst_n),
        .start_i   (start),
        .stop_i    (stop),
        .rand_i    (rand_v),
        .next_o    (next_v),
        .target_o  (target_v),
        .count_o   (count_v),
        .score_o   (score_v),
        .running_o (running_v),
        .correct_o (correct_v),
        .wrong_o   (wrong_v),
        .won_o     (won_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model LFSR (x^5 + x^3 + 1), advanced whenever the controller asks.
    always @(posedge clk) begin
        if (next_v) lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    end
    assign rand_v = lfsr;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Start edge from IDLE/WON through REQ and LOAD into RUN.
    task automatic begin_round(input logic [4:0] exp_target, input logic [2:0] exp_score);
        start = 1'b1;
        step();
        chk("req_next", next_v, 1);
        chk("req_score", score_v, exp_score);
        start = 1'b0;
        step();
        chk("load_next", next_v, 0);
        chk("load_running", running_v, 0);
        step();
        chk("run_running", running_v, 1);
        chk("run_target", target_v, exp_target);
        chk("run_count", count_v, 31);
    endtask

    // Finish the result hold of CORRECT and check the automatic next request.
    task automatic correct_to_req();
        step();
        chk("hold_correct1", correct_v, 1);
        step();
        chk("hold_correct2", correct_v, 1);
        step();
        chk("auto_req_next", next_v, 1);
        chk("auto_req_correct", correct_v, 0);
        step();
        chk("auto_load_next", next_v, 0);
        step();
    endtask

    initial begin
        rst_n = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        #1 rst_n = 1'b0;
        run_steps(2);
        chk("rst_state_flags", {next_v, running_v, correct_v, wrong_v, won_v}, 0);
        chk("rst_target", target_v, 0);
        chk("rst_count", count_v, 0);
        chk("rst_score", score_v, 0);
        rst_n = 1'b1;
        run_steps(2);

        // Round 1: target 2, stopped on count 2.
        begin_round(5'd2, 3'd0);
        run_steps(4 * (31 - 2));
        chk("r1_count_at_target", count_v, 2);
        stop = 1'b1;
        step();
        chk("r1_correct", correct_v, 1);
        chk("r1_score", score_v, 1);
        chk("r1_running", running_v, 0);
        chk("r1_count_held", count_v, 2);
        stop = 1'b0;
        correct_to_req();

        // Round 2: target 4, second correct round wins.
        chk("r2_running", running_v, 1);
        chk("r2_target", target_v, 4);
        chk("r2_count", count_v, 31);
        run_steps(4 * (31 - 4));
        stop = 1'b1;
        step();
        chk("r2_correct", correct_v, 1);
        chk("r2_score", score_v, 2);
        stop = 1'b0;
        run_steps(3);
        chk("won_flag", won_v, 1);
        chk("won_no_next", next_v, 0);
        run_steps(4);
        chk("won_held", won_v, 1);
        chk("won_score", score_v, 2);
        chk("won_target_held", target_v, 4);

        // Restart from WON: score clears with the request.
        begin_round(5'd9, 3'd0);
        run_steps(4 * (31 - 9));
        stop = 1'b1;
        step();
        chk("r3_correct", correct_v, 1);
        chk("r3_score", score_v, 1);
        stop = 1'b0;
        correct_to_req();

        // Round 4: target 18, simultaneous start+stop at count 31 -> WRONG.
        chk("r4_target", target_v, 18);
        start = 1'b1;
        stop  = 1'b1;
        step();
        chk("r4_wrong", wrong_v, 1);
        chk("r4_no_next", next_v, 0);
        chk("r4_score_kept", score_v, 1);
        chk("r4_count_held", count_v, 31);
        start = 1'b0;
        stop  = 1'b0;
        step();
        chk("r4_wrong_hold1", wrong_v, 1);
        step();
        chk("r4_wrong_hold2", wrong_v, 1);
        step();
        chk("r4_idle_wrong", wrong_v, 0);
        chk("r4_idle_score", score_v, 0);
        chk("r4_idle_target", target_v, 18);
        chk("r4_idle_count", count_v, 31);
        step();
        chk("r4_idle_flags", {next_v, running_v, correct_v, wrong_v, won_v}, 0);

        // Round 5: full count sequence, then stop on a decrement cycle.
        begin_round(5'd5, 3'd0);
        for (int i = 1; i <= 32; i++) begin
            run_steps(4);
            chk("seq_count", count_v, (31 - i) & 31);
        end
        run_steps(3);
        stop = 1'b1;
        step();
        chk("r5_wrong", wrong_v, 1);
        chk("r5_count_pre_dec", count_v, 31);
        stop = 1'b0;
        run_steps(3);
        chk("r5_idle", wrong_v, 0);

        // Round 6: target 11, stop edge on the cycle count 11 would decrement.
        begin_round(5'd11, 3'd0);
        run_steps(83);
        chk("r6_count_before", count_v, 11);
        stop = 1'b1;
        step();
        chk("r6_correct", correct_v, 1);
        chk("r6_count_pre_dec", count_v, 11);
        chk("r6_score", score_v, 1);
        stop = 1'b0;
        correct_to_req();

        // Round 7: reset asserted mid-RUN clears outputs without a clock edge.
        chk("r7_target", target_v, 22);
        run_steps(6);
        chk("r7_count", count_v, 30);
        rst_n = 1'b0;
        stop  = 1'b1;
        #1;
        chk("mid_rst_flags", {next_v, running_v, correct_v, wrong_v, won_v}, 0);
        chk("mid_rst_target", target_v, 0);
        chk("mid_rst_count", count_v, 0);
        chk("mid_rst_score", score_v, 0);
        run_steps(2);
        rst_n = 1'b1;
        step();

        // Stop held through reset release and LOAD never registers as a press.
        begin_round(5'd12, 3'd0);
        run_steps(5);
        chk("held_stop_running", running_v, 1);
        chk("held_stop_no_result", {correct_v, wrong_v}, 0);
        chk("held_stop_count", count_v, 30);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
